// File: rtl/pokey_div_chain_if.sv
// Control/status bundle for one POKEY divider stage.
// The stage consumes the control group and produces count, carry and wave outputs.
interface pokey_div_chain_if #(
    parameter int WIDTH = 8
);
    logic             enp;
    logic             enn;
    logic             tick;
    logic             load;
    logic             oneshot;
    logic [WIDTH-1:0] reload_val;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             ntc;
    logic             sq;
    logic             done;

    modport master (
        output enp, enn, tick, load, oneshot, reload_val,
        input  cnt, tc, ntc, sq, done
    );

    modport slave (
        input  enp, enn, tick, load, oneshot, reload_val,
        output cnt, tc, ntc, sq, done
    );
endinterface

// File: rtl/pokey_div_chain.sv
// Two-phase POKEY divider stage: count/reload on the falling edge, terminal carry on the rising edge.
// Stages cascade by feeding one stage's tc into the next stage's tick.
module pokey_div_chain #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            nrst,
    pokey_div_chain_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             term;

    // Load outranks the terminal event, so a colliding load never toggles sq or raises tc.
    always_comb begin
        term   = bus.tick & (cnt_q == '0) & ~bus.load & ~done_q;
        cnt_d  = cnt_q;
        sq_d   = sq_q;
        done_d = done_q;
        if (bus.enn) begin
            if (bus.load) begin
                cnt_d  = bus.reload_val;
                done_d = 1'b0;
            end else if (term) begin
                sq_d = ~sq_q;
                if (bus.oneshot) done_d = 1'b1;
                else             cnt_d  = bus.reload_val;
            end else if (bus.tick && (cnt_q != '0) && !done_q) begin
                cnt_d = cnt_q - ONE;
            end
        end
        tc_d = bus.enp ? term : tc_q;
    end

    always_ff @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q  <= RESET_VAL;
            sq_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sq_q   <= sq_d;
            done_q <= done_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tc_q <= 1'b0;
        else       tc_q <= tc_d;
    end

    assign bus.cnt  = cnt_q;
    assign bus.tc   = tc_q;
    assign bus.ntc  = ~tc_q;
    assign bus.sq   = sq_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pokey_div_chain.sv
// Bench for pokey_div_chain: an 8-bit stage, a 16-bit stage and a two-stage cascade
// checked cycle by cycle against a rule-level reference model through a scoreboard queue.
module tb_pokey_div_chain;
    typedef struct packed {
        logic [15:0] cnt;
        logic        tc;
        logic        sq;
        logic        done;
    } st_t;

    logic clk = 1'b0;
    logic nrst;
    int   n_chk = 0;
    int   n_fail = 0;

    bit          tk[4], ld[4], os[4], ep[4], en[4];
    logic [15:0] rv[4];
    st_t         m[4];
    st_t         expq[$];
    int          wid[4]  = '{8, 16, 8, 8};
    logic [15:0] rstv[4] = '{16'd3, 16'h1234, 16'd0, 16'd0};

    always #5 clk = ~clk;

    pokey_div_chain_if #(.WIDTH(8))  if0 ();
    pokey_div_chain_if #(.WIDTH(16)) if1 ();
    pokey_div_chain_if #(.WIDTH(8))  if2 ();
    pokey_div_chain_if #(.WIDTH(8))  if3 ();

    assign if3.tick = if2.tc;

    pokey_div_chain #(.WIDTH(8),  .RESET_VAL(8'd3))     u0 (.clk(clk), .nrst(nrst), .bus(if0));
    pokey_div_chain #(.WIDTH(16), .RESET_VAL(16'h1234)) u1 (.clk(clk), .nrst(nrst), .bus(if1));
    pokey_div_chain #(.WIDTH(8),  .RESET_VAL(8'd0))     u2 (.clk(clk), .nrst(nrst), .bus(if2));
    pokey_div_chain #(.WIDTH(8),  .RESET_VAL(8'd0))     u3 (.clk(clk), .nrst(nrst), .bus(if3));

    function automatic logic [15:0] msk(int s);
        return (wid[s] == 16) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic st_t act(int s);
        st_t a;
        a = '0;
        case (s)
            0: begin a.cnt = {8'h00, if0.cnt}; a.tc = if0.tc; a.sq = if0.sq; a.done = if0.done; end
            1: begin a.cnt = if1.cnt;          a.tc = if1.tc; a.sq = if1.sq; a.done = if1.done; end
            2: begin a.cnt = {8'h00, if2.cnt}; a.tc = if2.tc; a.sq = if2.sq; a.done = if2.done; end
            default: begin a.cnt = {8'h00, if3.cnt}; a.tc = if3.tc; a.sq = if3.sq; a.done = if3.done; end
        endcase
        return a;
    endfunction

    function automatic logic act_ntc(int s);
        case (s)
            0:       return if0.ntc;
            1:       return if1.ntc;
            2:       return if2.ntc;
            default: return if3.ntc;
        endcase
    endfunction

    task automatic chk(string nm, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
        end
    endtask

    task automatic cmp(int s, st_t e);
        st_t a;
        a = act(s);
        chk($sformatf("cnt%0d", s),  int'(a.cnt),     int'(e.cnt));
        chk($sformatf("tc%0d", s),   int'(a.tc),      int'(e.tc));
        chk($sformatf("ntc%0d", s),  int'(act_ntc(s)), int'(!e.tc));
        chk($sformatf("sq%0d", s),   int'(a.sq),      int'(e.sq));
        chk($sformatf("done%0d", s), int'(a.done),    int'(e.done));
    endtask

    // Reference model: one full clock = rising edge (carry sample) then falling edge (count).
    function automatic void model_reset();
        for (int s = 0; s < 4; s++) begin
            m[s].cnt = rstv[s]; m[s].tc = 1'b0; m[s].sq = 1'b0; m[s].done = 1'b0;
        end
    endfunction

    function automatic void model_cycle();
        bit tca_old, tkv, t;
        if (!nrst) begin
            model_reset();
            return;
        end
        tca_old = m[2].tc;
        for (int s = 0; s < 4; s++) begin
            tkv = (s == 3) ? tca_old : tk[s];
            if (ep[s]) m[s].tc = tkv && (m[s].cnt == 0) && !ld[s] && !m[s].done;
        end
        for (int s = 0; s < 4; s++) begin
            tkv = (s == 3) ? m[2].tc : tk[s];
            t = tkv && (m[s].cnt == 0) && !ld[s] && !m[s].done;
            if (en[s]) begin
                if (ld[s]) begin
                    m[s].cnt = rv[s] & msk(s); m[s].done = 1'b0;
                end else if (t) begin
                    m[s].sq = !m[s].sq;
                    if (os[s]) m[s].done = 1'b1;
                    else       m[s].cnt  = rv[s] & msk(s);
                end else if (tkv && m[s].cnt != 0 && !m[s].done) begin
                    m[s].cnt = m[s].cnt - 16'd1;
                end
            end
        end
    endfunction

    task automatic apply();
        if0.enp = ep[0]; if0.enn = en[0]; if0.tick = tk[0]; if0.load = ld[0];
        if0.oneshot = os[0]; if0.reload_val = rv[0][7:0];
        if1.enp = ep[1]; if1.enn = en[1]; if1.tick = tk[1]; if1.load = ld[1];
        if1.oneshot = os[1]; if1.reload_val = rv[1];
        if2.enp = ep[2]; if2.enn = en[2]; if2.tick = tk[2]; if2.load = ld[2];
        if2.oneshot = os[2]; if2.reload_val = rv[2][7:0];
        if3.enp = ep[3]; if3.enn = en[3]; if3.load = ld[3];
        if3.oneshot = os[3]; if3.reload_val = rv[3][7:0];
    endtask

    task automatic cyc();
        apply();
        model_cycle();
        for (int s = 0; s < 4; s++) expq.push_back(m[s]);
        @(negedge clk); #2;
    endtask

    task automatic async_rst();
        nrst = 1'b0;
        model_reset();
        #1;
        for (int s = 0; s < 4; s++) cmp(s, m[s]);
    endtask

    // Monitor: one falling edge retires the four predictions pushed before it.
    initial begin
        st_t e;
        forever begin
            @(negedge clk); #1;
            if (expq.size() >= 4) begin
                for (int s = 0; s < 4; s++) begin
                    e = expq.pop_front();
                    cmp(s, e);
                end
            end
        end
    end

    initial begin
        int ca, cb, c0, cs;
        logic pb;
        nrst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tk[s] = 0; ld[s] = 0; os[s] = 0; ep[s] = 1; en[s] = 1; rv[s] = 16'd0;
        end
        apply();
        #1 async_rst();
        @(negedge clk); #2;
        cyc();
        nrst = 1'b1;
        tk[0] = 1; tk[1] = 1;
        repeat (2) cyc();

        // basic count, 16-bit wrap via late reload_val change, and the cascade
        for (int s = 0; s < 4; s++) ld[s] = 1;
        rv[0] = 16'd3; rv[1] = 16'd1; rv[2] = 16'd1; rv[3] = 16'd2;
        cyc();
        for (int s = 0; s < 4; s++) ld[s] = 0;
        rv[1] = 16'hFFFF;
        tk[2] = 1;
        ca = 0; cb = 0; c0 = 0; cs = 0; pb = if3.sq;
        repeat (60) begin
            cyc();
            ca += int'(if2.tc); cb += int'(if3.tc); c0 += int'(if0.tc);
            if (if3.sq != pb) cs++;
            pb = if3.sq;
        end
        chk("tcA_pulses", ca, 30);
        chk("tcB_pulses", cb, 10);
        chk("tc0_pulses", c0, 15);
        chk("sqB_toggles", cs, 10);

        // enable gating
        en[0] = 0; repeat (3) cyc(); en[0] = 1;
        ep[0] = 0; repeat (6) cyc(); ep[0] = 1;

        // one-shot, then restart by load
        os[0] = 1; ld[0] = 1; rv[0] = 16'd2; cyc(); ld[0] = 0;
        repeat (6) cyc();
        ld[0] = 1; rv[0] = 16'd4; cyc(); ld[0] = 0;
        repeat (3) cyc();
        os[0] = 0; cyc();

        // load colliding with terminal count
        ld[0] = 1; rv[0] = 16'd5; cyc(); ld[0] = 0;
        chk("collision_cnt", int'(if0.cnt), 5);

        // async reset mid-count
        ld[1] = 1; rv[1] = 16'd5; cyc(); ld[1] = 0;
        repeat (3) cyc();
        async_rst(); cyc(); nrst = 1'b1;
        repeat (4) cyc();

        repeat (400) begin
            for (int s = 0; s < 4; s++) begin
                tk[s] = ($urandom % 8) != 0;
                ld[s] = ($urandom % 12) == 0;
                if ($urandom % 40 == 0) os[s] = !os[s];
                ep[s] = ($urandom % 10) != 0;
                en[s] = ($urandom % 10) != 0;
                if (s == 1) rv[s] = ($urandom % 5 == 0) ? 16'hFFFF : 16'($urandom % 6);
                else        rv[s] = ($urandom % 4 == 0) ? 16'($urandom % 256) : 16'($urandom % 6);
            end
            if ($urandom % 150 == 0) begin
                async_rst(); cyc(); nrst = 1'b1;
            end else begin
                cyc();
            end
        end
        @(negedge clk); #3;
        chk("queue_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pokey_div_chain.md
Name: pokey_div_chain

Overview:
- Parametrised two-phase down-counter for the POKEY audio and timer divider path.
- Generalises the single-bit ripple cell into one WIDTH-bit counter with:
  - synchronous load and auto-reload on underflow,
  - a registered terminal-carry output,
  - a square-wave output,
  - an optional one-shot mode.
- Instances cascade through tc -> tick to form 16-bit or longer dividers.
- Sits between the base-clock selector and the channel output/filter logic.

Parameters:
- WIDTH, 8, counter and reload width in bits; legal range 2..16.
- RESET_VAL, 0, value loaded into cnt on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; both edges used (posedge = phase P, negedge = phase N).
- nrst  input  1  asynchronous active-low reset.
- enp  input  1  phase-P enable; qualifies posedge registers.
- enn  input  1  phase-N enable; qualifies negedge registers.
- tick  input  1  count enable / carry-in from previous stage or base clock.
- load  input  1  force reload of cnt from reload_val.
- oneshot  input  1  1 = stop at zero instead of auto-reloading.
- reload_val  input  WIDTH  divider reload value (AUDF-style).
- cnt  output  WIDTH  current count value.
- tc  output  1  registered terminal carry.
- ntc  output  1  complement of tc.
- sq  output  1  square-wave output; toggles on each terminal reload.
- done  output  1  sticky one-shot completion flag.

Behaviour:
- Reset (nrst=0, asynchronous, overrides all enables): cnt=RESET_VAL, tc=0, ntc=1, sq=0, done=0. Outputs hold these values while nrst is low.
- Terminal condition: term = tick & (cnt==0) & ~load & ~done.
- Phase N (negedge clk, only when enn=1), first matching rule applies:
  1. load=1: cnt<=reload_val; done<=0. sq unchanged.
  2. term & ~oneshot: cnt<=reload_val; sq<=~sq.
  3. term & oneshot: cnt holds 0; done<=1; sq<=~sq.
  4. tick & cnt!=0 & ~done: cnt<=cnt-1, modulo 2^WIDTH arithmetic, no underflow past 0.
  5. Otherwise cnt, sq and done hold.
- Phase P (posedge clk, only when enp=1): tc<=term. ntc is always ~tc.
- tc timing:
  - tc is sampled at the posedge preceding the negedge that performs the reload.
  - It stays stable for the following full clock period.
  - A downstream stage using tc as its tick therefore sees it at its next phase-N edge.
- Divide ratio: in auto-reload with tick held high and both enables held high, the period is reload_val+1 N-edges.
  - tc is high for 1 of every reload_val+1 P-edges.
  - The sq period is 2*(reload_val+1) N-edges.
- reload_val=0 with tick held high: tc high on every P-edge; sq toggles on every N-edge.
- load and term on the same N-edge: load wins; no toggle; done cleared. term is gated by load, so tc is not set at the matching P-edge.
- done=1: tick is ignored; tc stays 0; cnt holds 0 until load.
- Enables low: the corresponding phase registers hold regardless of tick or load.
- Reset asserted mid-count: immediate return to reset values. After release, counting resumes from RESET_VAL at the first enabled N-edge.
- reload_val is sampled only at reload or load edges; changes mid-count take effect at the next reload.
- No combinational path from inputs to cnt, sq or done. tc is registered.

Test Plan:
- Reset and basic count (WIDTH=8): release nrst, pulse load with reload_val=3, then hold tick=1 and enp=enn=1 -> cnt sequence 3,2,1,0,3,2,...; tc high one clock per 4; sq toggles every 4 N-edges (period 8).
- Cascade: stage A (reload 1) tc drives stage B tick (reload 2), tick_A=1 -> B decrements once per 2 clocks; B tc asserts once per 6 clocks; B sq period 12.
- One-shot: oneshot=1, load 2, tick=1 -> cnt 2,1,0 then holds 0; done=1 after the third N-edge; a single sq toggle; tc stays 0 afterwards; a new load clears done and restarts the count.
- Collision: cnt=0, tick=1, load=1 with reload_val=5 on the same N-edge -> cnt=5, sq unchanged, tc=0 at the next P-edge.
- Enable gating: enn=0 for 3 clocks while tick=1 -> cnt frozen. enp=0 while term=1 -> tc holds its prior value.
- Async reset mid-count: drop nrst between edges at cnt=2 -> cnt=RESET_VAL, tc=0, sq=0, done=0 immediately without a clock edge. Repeat with WIDTH=16, reload_val=16'hFFFF and check wrap.
